// File: rtl/frame_pkg.sv
// Shared framing definitions for the header-inserting and header-stripping stages.
// Holds the default frame layout, the parser state encoding and the error-counter width.
package frame_pkg;

    // Default frame layout; both ends of the link must agree on these.
    localparam int unsigned DATA_BEATS_DEF = 129;
    localparam int unsigned META_BEATS_DEF = 3;
    localparam int unsigned SEQ_BEATS_DEF  = 2;

    localparam int unsigned ERR_CNT_W = 16;

    // Parser states.
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_DATA = 2'd0;
    localparam logic [STATE_W-1:0] S_META = 2'd1;
    localparam logic [STATE_W-1:0] S_SEQ  = 2'd2;

    // Largest of three beat counts, used to size the shared beat counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register carrying data and tlast.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i/in_data_i/in_last_i/in_ready_o   upstream beat and ready
//   out_valid_o/out_data_o/out_last_o/out_ready_i downstream beat and ready
module axis_out_reg #(
    parameter int unsigned DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    input  logic          out_ready_i
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          last_q,  last_d;

    // Accept whenever the slot is empty or being drained this cycle.
    assign in_ready_o = !valid_q || out_ready_i;

    // Next-state: load on accept, otherwise drain; data/last hold while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            last_d  = in_last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/frame_header_stripper.sv
// Receive-side frame parser: forwards data beats with tlast/tkeep, captures the
// metadata block and sequence value as sideband, and flags sequence faults.
// Optional feature: define FRAME_SEQ_CHECK_EN to also check frame-to-frame
// sequence continuity (previous + 1, first frame after reset exempt).
// Ports:
//   clk, resetn                               clock, asynchronous active-low reset
//   axis_in_tdata/tvalid/tready               framed input stream
//   axis_out_tdata/tvalid/tready/tlast/tkeep  data-only output stream
//   meta_tdata, meta_valid                    captured metadata block and completion pulse
//   seq_value, seq_valid, seq_error           frame sequence, completion and fault pulses
//   err_count                                 saturating sequence-fault count
module frame_header_stripper
    import frame_pkg::*;
#(
    parameter int unsigned DW         = 128,
    parameter int unsigned DATA_BEATS = DATA_BEATS_DEF,
    parameter int unsigned META_BEATS = META_BEATS_DEF,
    parameter int unsigned SEQ_BEATS  = SEQ_BEATS_DEF,
    parameter int unsigned SEQ_W      = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DW-1:0]            axis_in_tdata,
    input  logic                     axis_in_tvalid,
    output logic                     axis_in_tready,
    output logic [DW-1:0]            axis_out_tdata,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic                     axis_out_tlast,
    output logic [DW/8-1:0]          axis_out_tkeep,
    output logic [META_BEATS*DW-1:0] meta_tdata,
    output logic                     meta_valid,
    output logic [SEQ_W-1:0]         seq_value,
    output logic                     seq_valid,
    output logic                     seq_error,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int unsigned MAX_BEATS = max3(DATA_BEATS, META_BEATS, SEQ_BEATS);
    localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned MW        = META_BEATS * DW;
    localparam int unsigned KW        = DW / 8;

    logic [STATE_W-1:0]   state_q,      state_d;
    logic [CNT_W-1:0]     beat_cnt_q,   beat_cnt_d;
    logic [MW-1:0]        meta_q,       meta_d;
    logic                 meta_valid_q, meta_valid_d;
    logic [SEQ_W-1:0]     seq_first_q,  seq_first_d;
    logic                 mismatch_q,   mismatch_d;
    logic [SEQ_W-1:0]     seq_value_q,  seq_value_d;
    logic                 seq_valid_q,  seq_valid_d;
    logic                 seq_error_q,  seq_error_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

    logic             out_in_ready;
    logic             in_fire;
    logic             last_beat;
    logic [SEQ_W-1:0] in_seq;
    logic [SEQ_W-1:0] frame_seq;
    logic             cont_fault;
    logic             fault;

    assign in_seq = axis_in_tdata[SEQ_W-1:0];

    // Output back-pressure only gates data beats; header beats always drain.
    assign axis_in_tready = resetn && ((state_q == S_DATA) ? out_in_ready : 1'b1);
    assign in_fire        = axis_in_tvalid && axis_in_tready;

    // Last beat of the current section.
    always_comb begin
        last_beat = 1'b0;
        case (state_q)
            S_DATA:  last_beat = (beat_cnt_q == CNT_W'(DATA_BEATS - 1));
            S_META:  last_beat = (beat_cnt_q == CNT_W'(META_BEATS - 1));
            default: last_beat = (beat_cnt_q == CNT_W'(SEQ_BEATS - 1));
        endcase
    end

    // The frame sequence is always the first seq beat, even when it is also the last.
    assign frame_seq = (beat_cnt_q == '0) ? in_seq : seq_first_q;

`ifdef FRAME_SEQ_CHECK_EN
    logic [SEQ_W-1:0] exp_q, exp_d;
    logic             first_frame_q, first_frame_d;

    assign cont_fault = !first_frame_q && (frame_seq != exp_q);

    // Expected value resynchronises to whatever arrived, so one gap gives one fault.
    always_comb begin
        exp_d         = exp_q;
        first_frame_d = first_frame_q;
        if (in_fire && (state_q == S_SEQ) && last_beat) begin
            exp_d         = frame_seq + SEQ_W'(1);
            first_frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q         <= '0;
            first_frame_q <= 1'b1;
        end else begin
            exp_q         <= exp_d;
            first_frame_q <= first_frame_d;
        end
    end
`else
    assign cont_fault = 1'b0;
`endif

    // Next-state: section FSM, metadata capture and sequence checking.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        meta_d       = meta_q;
        meta_valid_d = 1'b0;
        seq_first_d  = seq_first_q;
        mismatch_d   = mismatch_q;
        seq_value_d  = seq_value_q;
        seq_valid_d  = 1'b0;
        seq_error_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        fault        = 1'b0;

        if (in_fire) begin
            if (last_beat) begin
                beat_cnt_d = '0;
                case (state_q)
                    S_DATA:  state_d = S_META;
                    S_META:  state_d = S_SEQ;
                    default: state_d = S_DATA;
                endcase
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end

            if (state_q == S_META) begin
                for (int unsigned k = 0; k < META_BEATS; k++) begin
                    if (beat_cnt_q == CNT_W'(k)) begin
                        meta_d[k*DW +: DW] = axis_in_tdata;
                    end
                end
                meta_valid_d = last_beat;
            end

            if (state_q == S_SEQ) begin
                if (beat_cnt_q == '0) begin
                    seq_first_d = in_seq;
                    mismatch_d  = 1'b0;
                end else if (in_seq != seq_first_q) begin
                    mismatch_d = 1'b1;
                end
                if (last_beat) begin
                    fault       = mismatch_d || cont_fault;
                    seq_value_d = frame_seq;
                    seq_valid_d = 1'b1;
                    seq_error_d = fault;
                    mismatch_d  = 1'b0;
                    if (fault && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_DATA;
            beat_cnt_q   <= '0;
            meta_q       <= '0;
            meta_valid_q <= 1'b0;
            seq_first_q  <= '0;
            mismatch_q   <= 1'b0;
            seq_value_q  <= '0;
            seq_valid_q  <= 1'b0;
            seq_error_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            meta_q       <= meta_d;
            meta_valid_q <= meta_valid_d;
            seq_first_q  <= seq_first_d;
            mismatch_q   <= mismatch_d;
            seq_value_q  <= seq_value_d;
            seq_valid_q  <= seq_valid_d;
            seq_error_q  <= seq_error_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    axis_out_reg #(
        .DW (DW)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (resetn),
        .in_valid_i  (axis_in_tvalid && (state_q == S_DATA)),
        .in_data_i   (axis_in_tdata),
        .in_last_i   (beat_cnt_q == CNT_W'(DATA_BEATS - 1)),
        .in_ready_o  (out_in_ready),
        .out_valid_o (axis_out_tvalid),
        .out_data_o  (axis_out_tdata),
        .out_last_o  (axis_out_tlast),
        .out_ready_i (axis_out_tready)
    );

    assign axis_out_tkeep = {KW{axis_out_tvalid}};
    assign meta_tdata     = meta_q;
    assign meta_valid     = meta_valid_q;
    assign seq_value      = seq_value_q;
    assign seq_valid      = seq_valid_q;
    assign seq_error      = seq_error_q;
    assign err_count      = err_cnt_q;

endmodule

// File: doc/frame_header_stripper.md
# frame_header_stripper

Receive-side companion that sits directly downstream of the header-inserting stage on one output path. It parses the fixed framing (data beats, then metadata beats, then sequence-counter beats) from a single AXI-Stream. It forwards only the data beats with tlast/tkeep generated, and captures the metadata block and sequence value as sideband outputs. Optionally, it checks sequence continuity across frames.

## Interface
- DW, 128, stream data width (bits)
- DATA_BEATS, 129, data beats per frame (≥2)
- META_BEATS, 3, metadata beats per frame (≥1)
- SEQ_BEATS, 2, sequence-counter beats per frame (≥1)
- SEQ_W, 32, sequence field width, taken from tdata[SEQ_W-1:0] (≤DW)
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- axis_in_tdata / axis_in_tvalid / axis_in_tready  in/in/out  DW/1/1  framed input stream
- axis_out_tdata / axis_out_tvalid / axis_out_tready  out/out/in  DW/1/1  data-only output stream
- axis_out_tlast  out  1  high on last data beat of a frame
- axis_out_tkeep  out  DW/8  all ones whenever axis_out_tvalid
- meta_tdata  out  META_BEATS*DW  captured metadata; beat 0 in LSBs
- meta_valid  out  1  one-cycle pulse, metadata block complete
- seq_value  out  SEQ_W  last captured sequence value
- seq_valid  out  1  one-cycle pulse, frame complete
- seq_error  out  1  one-cycle pulse, sequence fault at frame end
- err_count  out  16  saturating sequence-fault count

## Operation
- FSM states: S_DATA → S_META → S_SEQ → S_DATA. Reset state is S_DATA.
- beat_cnt counts accepted beats (tvalid&&tready) within the current state. It clears on each state change.
- State transitions occur on acceptance of the last beat of each state: beat_cnt==DATA_BEATS-1, META_BEATS-1 or SEQ_BEATS-1.
- Gaps in tvalid never advance any counter.
- S_DATA:
  - axis_in_tready = !axis_out_tvalid || axis_out_tready (single-register output stage).
  - An accepted beat loads the output register: tvalid=1, tlast=(beat_cnt==DATA_BEATS-1).
- S_META:
  - axis_in_tready=1.
  - Beat k is written into meta_tdata[k*DW +: DW].
  - meta_valid pulses the cycle after the last meta beat is accepted.
  - meta_tdata holds until the next frame's meta beats overwrite it.
- S_SEQ:
  - axis_in_tready=1.
  - The first seq beat's low SEQ_W bits are captured as the frame sequence.
  - Any later seq beat of the same frame with different low bits sets an intra-frame mismatch flag.
  - On the last seq beat: seq_value updates, seq_valid pulses, and seq_error pulses if the mismatch flag (or the continuity check, see Configuration) failed.
  - err_count increments on each seq_error and saturates at 16'hFFFF.
- Output register keeps tdata/tlast stable while tvalid && !tready.
- axis_in_tready is 0 while resetn is low.
- Reset mid-frame discards the partial frame. Parsing resumes at data beat 0.

## Timing
- Reset values: all outputs 0. Internal state is S_DATA, beat_cnt 0, mismatch flag 0, first-frame flag 1.
- Data path latency: 1 cycle from input acceptance to axis_out_tvalid.
- Throughput: one beat per cycle when the output is not stalled.
- meta_valid, seq_valid and seq_error are registered. They assert the cycle after the accepting edge, for exactly one cycle.
- Output back-pressure stalls input only in S_DATA. Meta and seq beats are accepted even while output is stalled.
- Sequence arithmetic is modulo 2^SEQ_W: an expected value of 2^SEQ_W-1 wraps to 0 without error.

## Configuration
- FRAME_SEQ_CHECK_EN defined:
  - Each frame's sequence must equal the previous frame's sequence + 1 (mod 2^SEQ_W).
  - The first frame after reset is exempt and only seeds the expected value.
  - A mismatch asserts seq_error. The expected value then resynchronises to the received value + 1.
- Undefined: only the intra-frame mismatch check drives seq_error. The expected-value register and comparator are absent.

## Structure
- Shared package frame_pkg holds:
  - state enum (S_DATA, S_META, S_SEQ);
  - default DATA_BEATS/META_BEATS/SEQ_BEATS constants, also used by the header-inserting stage so both ends agree on framing;
  - ERR_CNT_W=16.
- One sub-module, axis_out_reg: a single-entry AXI-Stream output register (data, tlast) with the tready rule above.

## Test plan
Directed tests use DW=128, DATA_BEATS=4, META_BEATS=3, SEQ_BEATS=2, SEQ_W=32.
- Clean frame:
  - Stimulus: data 1,2,3,4; meta A,B,C; seq 7,7; out_tready=1.
  - Response: out 1,2,3,4 with tlast only on 4 and tkeep=16'hFFFF; meta_tdata={C,B,A} with one meta_valid pulse; seq_value=7 with seq_valid pulse; seq_error=0.
- Back-pressure: out_tready=0 for 5 cycles after data beat 2.
  - Response: in_tready=0 in S_DATA; beat 2 held stable; no beat lost or duplicated.
- Intra-frame mismatch: seq beats 9,10.
  - Response: seq_error pulse, err_count=1, seq_value=9.
- Continuity (FRAME_SEQ_CHECK_EN defined):
  - Frames with seq 5,6,8,9 → one seq_error, on the frame with 8 only.
  - Seq FFFFFFFF then 0 → no error.
- Bubbles and reset:
  - Random tvalid gaps → same output as the clean frame.
  - resetn low after meta beat B → outputs 0. The next frame parses from data beat 0, and err_count stays 0 throughout.
